// File: rtl/axi_mem_pkg.sv
// Shared encodings for the AXI memory responder: response codes, burst code and FSM states.
package axi_mem_pkg;

  localparam logic [1:0] RespOkay   = 2'b00;
  localparam logic [1:0] RespSlverr = 2'b10;
  localparam logic [1:0] BurstIncr  = 2'b01;

  typedef enum logic [1:0] {WIdle, WData, WResp} w_state_e;
  typedef enum logic [1:0] {RIdle, RFetch, RData} r_state_e;

endpackage

// File: rtl/axi_mem_ram.sv
// Simple dual-port RAM: one byte-enabled write port, one registered read-first read port.
module axi_mem_ram #(
  parameter int unsigned Depth = 1024,
  parameter int unsigned Width = 32,
  localparam int unsigned AddrW = $clog2(Depth)
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               we_i,
  input  logic [AddrW-1:0]   waddr_i,
  input  logic [Width/8-1:0] wstrb_i,
  input  logic [Width-1:0]   wdata_i,
  input  logic               re_i,
  input  logic [AddrW-1:0]   raddr_i,
  output logic [Width-1:0]   rdata_o
);

  logic [Width-1:0] mem_q [Depth];
  logic [Width-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      for (int b = 0; b < Width / 8; b++) begin
        if (wstrb_i[b]) mem_q[waddr_i][b*8 +: 8] <= wdata_i[b*8 +: 8];
      end
    end
  end

  // Only the read register is reset; array contents survive reset.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rdata_q <= '0;
    end else if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/axi_mem_responder.sv
// AXI4 INCR-burst memory responder backed by an internal RAM; independent write/read FSMs.
// Define AXI_RESP_RANGE_CHK_EN to answer beats beyond MEM_DEPTH with SLVERR instead of wrapping.
module axi_mem_responder
  import axi_mem_pkg::*;
#(
  parameter int unsigned C_AXI_ID_WIDTH   = 10,
  parameter int unsigned C_AXI_ADDR_WIDTH = 32,
  parameter int unsigned C_AXI_DATA_WIDTH = 32,
  parameter int unsigned MEM_DEPTH        = 1024
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [C_AXI_ID_WIDTH-1:0]     axi_awid,
  input  logic [C_AXI_ADDR_WIDTH-1:0]   axi_awaddr,
  input  logic [7:0]                    axi_awlen,
  input  logic [2:0]                    axi_awsize,
  input  logic [1:0]                    axi_awburst,
  input  logic                          axi_awvalid,
  output logic                          axi_awready,
  input  logic [C_AXI_DATA_WIDTH-1:0]   axi_wdata,
  input  logic [C_AXI_DATA_WIDTH/8-1:0] axi_wstrb,
  input  logic                          axi_wlast,
  input  logic                          axi_wvalid,
  output logic                          axi_wready,
  output logic [C_AXI_ID_WIDTH-1:0]     axi_bid,
  output logic [1:0]                    axi_bresp,
  output logic                          axi_bvalid,
  input  logic                          axi_bready,
  input  logic [C_AXI_ID_WIDTH-1:0]     axi_arid,
  input  logic [C_AXI_ADDR_WIDTH-1:0]   axi_araddr,
  input  logic [7:0]                    axi_arlen,
  input  logic [2:0]                    axi_arsize,
  input  logic [1:0]                    axi_arburst,
  input  logic                          axi_arvalid,
  output logic                          axi_arready,
  output logic [C_AXI_ID_WIDTH-1:0]     axi_rid,
  output logic [C_AXI_DATA_WIDTH-1:0]   axi_rdata,
  output logic [1:0]                    axi_rresp,
  output logic                          axi_rlast,
  output logic                          axi_rvalid,
  input  logic                          axi_rready,
  output logic                          idle,
  output logic                          proto_err
);

  localparam int unsigned OffsW  = $clog2(C_AXI_DATA_WIDTH / 8);
  localparam int unsigned DepthW = $clog2(MEM_DEPTH);
`ifdef AXI_RESP_RANGE_CHK_EN
  // Keep the unwrapped word index (one spare bit absorbs len overflow) for range checking.
  localparam int unsigned IdxW = C_AXI_ADDR_WIDTH - OffsW + 1;
`else
  localparam int unsigned IdxW = DepthW;
`endif

  function automatic logic [IdxW-1:0] word_idx(input logic [C_AXI_ADDR_WIDTH-1:0] addr);
`ifdef AXI_RESP_RANGE_CHK_EN
    return {1'b0, addr[C_AXI_ADDR_WIDTH-1:OffsW]};
`else
    return addr[OffsW +: DepthW];
`endif
  endfunction

  w_state_e w_state_q, w_state_d;
  r_state_e r_state_q, r_state_d;
  logic     awready_q, awready_d, wready_q, wready_d, bvalid_q, bvalid_d;
  logic     arready_q, arready_d, rvalid_q, rvalid_d;

  logic [C_AXI_ID_WIDTH-1:0] wid_q, rid_q;
  logic [IdxW-1:0]           waddr_q, raddr_q, raddr_inc, ar_idx;
  logic [7:0]                wlen_q, wcnt_q, rlen_q, rcnt_q;
  logic                      werr_q, proto_err_q;
  logic [1:0]                bresp_q;

  logic aw_hs, w_hs, b_hs, ar_hs, r_hs;
  logic w_last_beat, r_last_beat, w_oor, r_oor;
  logic                        ram_we, ram_re;
  logic [DepthW-1:0]           ram_raddr;
  logic [C_AXI_DATA_WIDTH-1:0] ram_rdata;

  assign aw_hs       = awready_q & axi_awvalid;
  assign w_hs        = wready_q & axi_wvalid;
  assign b_hs        = bvalid_q & axi_bready;
  assign ar_hs       = arready_q & axi_arvalid;
  assign r_hs        = rvalid_q & axi_rready;
  assign w_last_beat = (wcnt_q == wlen_q);
  assign r_last_beat = (rcnt_q == rlen_q);
  assign ar_idx      = word_idx(axi_araddr);
  assign raddr_inc   = raddr_q + IdxW'(1);

`ifdef AXI_RESP_RANGE_CHK_EN
  assign w_oor = (waddr_q[IdxW-1:DepthW] != '0);
  assign r_oor = (raddr_q[IdxW-1:DepthW] != '0);
`else
  assign w_oor = 1'b0;
  assign r_oor = 1'b0;
`endif

  // Size, burst type and byte-offset bits are deliberately ignored.
  logic unused_inputs;
  assign unused_inputs = ^{axi_awaddr, axi_awsize, axi_awburst == BurstIncr,
                           axi_araddr, axi_arsize, axi_arburst == BurstIncr};

  // Write FSM next state.
  always_comb begin
    w_state_d = w_state_q;
    unique case (w_state_q)
      WIdle:   if (aw_hs) w_state_d = WData;
      WData:   if (w_hs && w_last_beat) w_state_d = WResp;
      WResp:   if (b_hs) w_state_d = WIdle;
      default: w_state_d = WIdle;
    endcase
  end

  // Write FSM outputs, registered from the next state so readies never depend on valids.
  always_comb begin
    awready_d = (w_state_d == WIdle);
    wready_d  = (w_state_d == WData);
    bvalid_d  = (w_state_d == WResp);
  end

  always_comb begin
    r_state_d = r_state_q;
    unique case (r_state_q)
      RIdle:   if (ar_hs) r_state_d = RFetch;
      RFetch:  r_state_d = RData;
      RData:   if (r_hs && r_last_beat) r_state_d = RIdle;
      default: r_state_d = RIdle;
    endcase
  end

  always_comb begin
    arready_d = (r_state_d == RIdle);
    rvalid_d  = (r_state_d == RData);
    ram_re    = ar_hs | (r_hs & ~r_last_beat);
    ram_raddr = ar_hs ? ar_idx[DepthW-1:0] : raddr_inc[DepthW-1:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      w_state_q <= WIdle;
      r_state_q <= RIdle;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
    end else begin
      w_state_q <= w_state_d;
      r_state_q <= r_state_d;
      awready_q <= awready_d;
      wready_q  <= wready_d;
      bvalid_q  <= bvalid_d;
      arready_q <= arready_d;
      rvalid_q  <= rvalid_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wid_q       <= '0;
      waddr_q     <= '0;
      wlen_q      <= '0;
      wcnt_q      <= '0;
      werr_q      <= 1'b0;
      bresp_q     <= RespOkay;
      proto_err_q <= 1'b0;
      rid_q       <= '0;
      raddr_q     <= '0;
      rlen_q      <= '0;
      rcnt_q      <= '0;
    end else begin
      if (aw_hs) begin
        wid_q   <= axi_awid;
        waddr_q <= word_idx(axi_awaddr);
        wlen_q  <= axi_awlen;
        wcnt_q  <= '0;
        werr_q  <= 1'b0;
      end
      if (w_hs) begin
        waddr_q <= waddr_q + IdxW'(1);
        wcnt_q  <= wcnt_q + 8'd1;
        werr_q  <= werr_q | w_oor;
        // Length always comes from awlen; a misplaced wlast is only flagged.
        if (axi_wlast != w_last_beat) proto_err_q <= 1'b1;
        if (w_last_beat) bresp_q <= (werr_q | w_oor) ? RespSlverr : RespOkay;
      end
      if (ar_hs) begin
        rid_q   <= axi_arid;
        raddr_q <= ar_idx;
        rlen_q  <= axi_arlen;
        rcnt_q  <= '0;
      end else if (r_hs && !r_last_beat) begin
        raddr_q <= raddr_inc;
        rcnt_q  <= rcnt_q + 8'd1;
      end
    end
  end

  assign ram_we = w_hs & ~w_oor;

  axi_mem_ram #(
    .Depth (MEM_DEPTH),
    .Width (C_AXI_DATA_WIDTH)
  ) u_ram (
    .clk_i   (clk),
    .rst_i   (rst),
    .we_i    (ram_we),
    .waddr_i (waddr_q[DepthW-1:0]),
    .wstrb_i (axi_wstrb),
    .wdata_i (axi_wdata),
    .re_i    (ram_re),
    .raddr_i (ram_raddr),
    .rdata_o (ram_rdata)
  );

  assign axi_awready = awready_q;
  assign axi_wready  = wready_q;
  assign axi_bvalid  = bvalid_q;
  assign axi_bid     = wid_q;
  assign axi_bresp   = bresp_q;
  assign axi_arready = arready_q;
  assign axi_rvalid  = rvalid_q;
  assign axi_rid     = rid_q;
  assign axi_rdata   = r_oor ? '0 : ram_rdata;
  assign axi_rresp   = r_oor ? RespSlverr : RespOkay;
  assign axi_rlast   = rvalid_q & r_last_beat;
  assign idle        = (w_state_q == WIdle) && (r_state_q == RIdle);
  assign proto_err   = proto_err_q;

endmodule

// File: tb/tb_axi_mem_responder.sv
// Self-checking bench for axi_mem_responder: directed steps plus random bursts against a word-array
// model of the memory.
module tb_axi_mem_responder;

  localparam int unsigned IdW   = 10;
  localparam int unsigned AddrW = 32;
  localparam int unsigned DataW = 32;
  localparam int unsigned Depth = 1024;
`ifdef AXI_RESP_RANGE_CHK_EN
  localparam int unsigned RangeLim = Depth;
`else
  localparam int unsigned RangeLim = 32'hffff_ffff;
`endif

  logic             clk = 1'b0;
  logic             rst;
  logic [IdW-1:0]   axi_awid, axi_arid, axi_bid, axi_rid;
  logic [AddrW-1:0] axi_awaddr, axi_araddr;
  logic [7:0]       axi_awlen, axi_arlen;
  logic [2:0]       axi_awsize, axi_arsize;
  logic [1:0]       axi_awburst, axi_arburst, axi_bresp, axi_rresp;
  logic             axi_awvalid, axi_awready, axi_wlast, axi_wvalid, axi_wready;
  logic             axi_bvalid, axi_bready, axi_arvalid, axi_arready;
  logic             axi_rlast, axi_rvalid, axi_rready, idle, proto_err;
  logic [DataW-1:0] axi_wdata, axi_rdata;
  logic [3:0]       axi_wstrb;

  always #5 clk = ~clk;

  axi_mem_responder #(
    .C_AXI_ID_WIDTH   (IdW),
    .C_AXI_ADDR_WIDTH (AddrW),
    .C_AXI_DATA_WIDTH (DataW),
    .MEM_DEPTH        (Depth)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .axi_awid    (axi_awid),
    .axi_awaddr  (axi_awaddr),
    .axi_awlen   (axi_awlen),
    .axi_awsize  (axi_awsize),
    .axi_awburst (axi_awburst),
    .axi_awvalid (axi_awvalid),
    .axi_awready (axi_awready),
    .axi_wdata   (axi_wdata),
    .axi_wstrb   (axi_wstrb),
    .axi_wlast   (axi_wlast),
    .axi_wvalid  (axi_wvalid),
    .axi_wready  (axi_wready),
    .axi_bid     (axi_bid),
    .axi_bresp   (axi_bresp),
    .axi_bvalid  (axi_bvalid),
    .axi_bready  (axi_bready),
    .axi_arid    (axi_arid),
    .axi_araddr  (axi_araddr),
    .axi_arlen   (axi_arlen),
    .axi_arsize  (axi_arsize),
    .axi_arburst (axi_arburst),
    .axi_arvalid (axi_arvalid),
    .axi_arready (axi_arready),
    .axi_rid     (axi_rid),
    .axi_rdata   (axi_rdata),
    .axi_rresp   (axi_rresp),
    .axi_rlast   (axi_rlast),
    .axi_rvalid  (axi_rvalid),
    .axi_rready  (axi_rready),
    .idle        (idle),
    .proto_err   (proto_err)
  );

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;
  logic [31:0] mem_m [Depth];
  logic [31:0] wd_q[$];
  logic [3:0]  ws_q[$];
  logic [31:0] ed_q[$];
  logic [1:0]  er_q[$];
  int          rd_cyc;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int unsigned beat_idx(input logic [31:0] addr, input int i);
    return 32'(addr >> 2) + 32'(i);
  endfunction

  task automatic gen_burst(input int len, input bit rnd_strb);
    wd_q.delete();
    ws_q.delete();
    for (int i = 0; i <= len; i++) begin
      wd_q.push_back($urandom);
      ws_q.push_back(rnd_strb ? 4'($urandom_range(0, 15)) : 4'hf);
    end
  endtask

  // Expected read beats from the model: wrapped words, or zero/SLVERR past the end when checked.
  task automatic build_exp(input logic [31:0] addr, input int len);
    int unsigned idx;
    logic [9:0]  widx;
    ed_q.delete();
    er_q.delete();
    for (int i = 0; i <= len; i++) begin
      idx  = beat_idx(addr, i);
      widx = 10'(idx);
      if (idx < RangeLim) begin
        ed_q.push_back(mem_m[widx]);
        er_q.push_back(2'b00);
      end else begin
        ed_q.push_back(32'h0);
        er_q.push_back(2'b10);
      end
    end
  endtask

  task automatic do_write(input logic [31:0] addr, input int len, input logic [IdW-1:0] id,
                          input logic [31:0] wd[$], input logic [3:0] ws[$],
                          input int bad_last, input int bdelay);
    int          t;
    int unsigned idx;
    logic [9:0]  widx;
    logic [1:0]  exp_resp;
    exp_resp    = 2'b00;
    axi_bready  = 1'b0;
    axi_awid    = id;
    axi_awaddr  = addr;
    axi_awlen   = 8'(len);
    axi_awsize  = 3'd2;
    axi_awburst = 2'($urandom_range(0, 2));
    axi_awvalid = 1'b1;
    t = 0;
    while (axi_awready !== 1'b1 && t < 50) begin
      @(posedge clk); #1;
      t++;
    end
    chk("aw_wait", t < 50, 1);
    @(posedge clk); #1;
    axi_awvalid = 1'b0;
    for (int i = 0; i <= len; i++) begin
      axi_wvalid = 1'b1;
      axi_wdata  = wd[i];
      axi_wstrb  = ws[i];
      axi_wlast  = (i == len) ^ (i == bad_last);
      chk("wready", axi_wready, 1);
      idx  = beat_idx(addr, i);
      widx = 10'(idx);
      if (idx < RangeLim) begin
        for (int b = 0; b < 4; b++) if (ws[i][b]) mem_m[widx][b*8 +: 8] = wd[i][b*8 +: 8];
      end else begin
        exp_resp = 2'b10;
      end
      @(posedge clk); #1;
    end
    axi_wvalid = 1'b0;
    axi_wlast  = 1'b0;
    chk("bvalid", axi_bvalid, 1);
    chk("bid", axi_bid, id);
    chk("bresp", axi_bresp, exp_resp);
    chk("wready_off", axi_wready, 0);
    for (int d = 0; d < bdelay; d++) begin
      @(posedge clk); #1;
      chk("bvalid_hold", axi_bvalid, 1);
    end
    axi_bready = 1'b1;
    @(posedge clk); #1;
    axi_bready = 1'b0;
    chk("bvalid_drop", axi_bvalid, 0);
  endtask

  // mode 0: rready always high, 1: toggling, 2: random.
  task automatic do_read(input logic [31:0] addr, input int len, input logic [IdW-1:0] id,
                         input logic [31:0] ed[$], input logic [1:0] er[$], input int mode,
                         output int cyc);
    int t, i;
    axi_arid    = id;
    axi_araddr  = addr;
    axi_arlen   = 8'(len);
    axi_arsize  = 3'd2;
    axi_arburst = 2'($urandom_range(0, 2));
    axi_arvalid = 1'b1;
    axi_rready  = 1'b0;
    t = 0;
    while (axi_arready !== 1'b1 && t < 50) begin
      @(posedge clk); #1;
      t++;
    end
    chk("ar_wait", t < 50, 1);
    @(posedge clk); #1;
    axi_arvalid = 1'b0;
    chk("rvalid_fetch", axi_rvalid, 0);
    @(posedge clk); #1;
    cyc = 1;
    chk("ar_to_rvalid", axi_rvalid, 1);
    i = 0;
    while (i <= len && cyc < 2000) begin
      axi_rready = (mode == 0) ? 1'b1 : (mode == 1) ? cyc[0] : 1'($urandom_range(0, 1));
      if (axi_rvalid === 1'b1) begin
        chk("rdata", axi_rdata, ed[i]);
        chk("rresp", axi_rresp, er[i]);
        chk("rlast", axi_rlast, i == len);
        chk("rid", axi_rid, id);
        if (axi_rready) i++;
      end
      @(posedge clk); #1;
      cyc++;
    end
    axi_rready = 1'b0;
    chk("r_beats", i, len + 1);
    chk("rvalid_drop", axi_rvalid, 0);
    if (mode == 0) chk("r_throughput", cyc, len + 2);
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] addr;
    int          len;
    rst = 1'b1;
    {axi_awid, axi_awaddr, axi_awlen, axi_awsize, axi_awburst, axi_awvalid} = '0;
    {axi_wdata, axi_wstrb, axi_wlast, axi_wvalid, axi_bready} = '0;
    {axi_arid, axi_araddr, axi_arlen, axi_arsize, axi_arburst, axi_arvalid, axi_rready} = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_awready", axi_awready, 0);
    chk("rst_wready", axi_wready, 0);
    chk("rst_bvalid", axi_bvalid, 0);
    chk("rst_arready", axi_arready, 0);
    chk("rst_rvalid", axi_rvalid, 0);
    chk("rst_rlast", axi_rlast, 0);
    chk("rst_resp", {axi_bresp, axi_rresp}, 0);
    chk("rst_ids", {axi_bid, axi_rid}, 0);
    chk("rst_rdata", axi_rdata, 0);
    chk("rst_proto_err", proto_err, 0);
    chk("rst_idle", idle, 1);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("awready_after_rst", axi_awready, 1);
    chk("arready_after_rst", axi_arready, 1);

    // Fill the whole RAM so every model word is known.
    for (int k = 0; k < 4; k++) begin
      gen_burst(255, 1'b0);
      do_write(32'(k * 1024), 255, IdW'(k), wd_q, ws_q, -1, 0);
    end

    // Incrementing pattern, then full-speed readback.
    wd_q.delete();
    ws_q.delete();
    for (int i = 1; i <= 8; i++) begin
      wd_q.push_back(32'(i * 32'h11));
      ws_q.push_back(4'hf);
    end
    do_write(32'h0, 7, 10'h2a5, wd_q, ws_q, -1, 0);
    build_exp(32'h0, 7);
    do_read(32'h0, 7, 10'h1c3, ed_q, er_q, 0, rd_cyc);

    // Partial strobes over a zeroed word.
    wd_q = '{32'h0};
    ws_q = '{4'hf};
    do_write(32'h0, 0, 10'h1, wd_q, ws_q, -1, 1);
    wd_q = '{32'haabbccdd};
    ws_q = '{4'b0101};
    do_write(32'h0, 0, 10'h2, wd_q, ws_q, -1, 2);
    ed_q = '{32'h00bb00dd};
    er_q = '{2'b00};
    do_read(32'h0, 0, 10'h3, ed_q, er_q, 0, rd_cyc);

    // 16-beat read with rready toggling.
    build_exp(32'h0000_0340, 15);
    do_read(32'h0000_0340, 15, 10'h3ff, ed_q, er_q, 1, rd_cyc);

    // Early wlast: flagged, but all four beats still land and one B follows.
    chk("proto_err_clean", proto_err, 0);
    gen_burst(3, 1'b0);
    do_write(32'h0000_0500, 3, 10'h77, wd_q, ws_q, 1, 0);
    chk("proto_err_set", proto_err, 1);
    for (int d = 0; d < 3; d++) begin
      @(posedge clk); #1;
      chk("single_b", axi_bvalid, 0);
    end
    chk("idle_after_write", idle, 1);
    build_exp(32'h0000_0500, 3);
    do_read(32'h0000_0500, 3, 10'h78, ed_q, er_q, 2, rd_cyc);

    // Concurrent write and read of the same region: the read sees prior contents.
    build_exp(32'h0000_0100, 7);
    gen_burst(7, 1'b0);
    fork
      do_write(32'h0000_0100, 7, 10'h155, wd_q, ws_q, -1, 0);
      do_read(32'h0000_0100, 7, 10'h0aa, ed_q, er_q, 0, rd_cyc);
    join
    chk("concurrent_cycles", rd_cyc + 1, 10);
    build_exp(32'h0000_0100, 7);
    do_read(32'h0000_0100, 7, 10'h0ab, ed_q, er_q, 0, rd_cyc);

    // Burst across the top of the memory.
    gen_burst(3, 1'b0);
    do_write(32'((Depth - 2) * 4), 3, 10'h200, wd_q, ws_q, -1, 0);
    build_exp(32'((Depth - 2) * 4), 3);
    do_read(32'((Depth - 2) * 4), 3, 10'h201, ed_q, er_q, 0, rd_cyc);
    build_exp(32'h0, 1);
    do_read(32'h0, 1, 10'h202, ed_q, er_q, 0, rd_cyc);

    // Random bursts, some near the top of the memory, random strobes and stalls.
    for (int it = 0; it < 20; it++) begin
      len  = $urandom_range(0, 15);
      addr = (it % 4 == 0) ? 32'((Depth - $urandom_range(1, 4)) * 4)
                           : 32'($urandom_range(0, Depth - 1) * 4);
      addr = addr + 32'($urandom_range(0, 3));
      gen_burst(len, 1'b1);
      do_write(addr, len, IdW'($urandom), wd_q, ws_q, -1, $urandom_range(0, 2));
      build_exp(addr, len);
      do_read(addr, len, IdW'($urandom), ed_q, er_q, 2, rd_cyc);
    end

    // Reset in the middle of a write burst: the two accepted beats stay in RAM.
    axi_awid    = 10'h3;
    axi_awaddr  = 32'h0000_0200;
    axi_awlen   = 8'd7;
    axi_awvalid = 1'b1;
    @(posedge clk); #1;
    axi_awvalid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      axi_wvalid = 1'b1;
      axi_wdata  = $urandom;
      axi_wstrb  = 4'hf;
      axi_wlast  = 1'b0;
      chk("mid_wready", axi_wready, 1);
      mem_m[10'(128 + i)] = axi_wdata;
      @(posedge clk); #1;
    end
    axi_wvalid = 1'b0;
    rst = 1'b1;
    #1;
    chk("mid_rst_readies", {axi_awready, axi_wready, axi_arready}, 0);
    chk("mid_rst_valids", {axi_bvalid, axi_rvalid}, 0);
    chk("mid_rst_idle", idle, 1);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    chk("mid_rst_awready", axi_awready, 1);
    build_exp(32'h0000_0200, 7);
    do_read(32'h0000_0200, 7, 10'h4, ed_q, er_q, 0, rd_cyc);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/axi_mem_responder.md
# axi_mem_responder

AXI4 memory responder (slave) for the DDR-side AXI interface: accepts INCR bursts from the DDR AXI master, stores write data in an internal RAM, and returns read data from that RAM. It stands in for the MIG/DDR controller in simulation and board-level loopback builds. It also serves as an on-chip scratch memory behind the same AXI port. Write and read channels run independently and concurrently.

## Interface
- C_AXI_ID_WIDTH, 10, ID width for AW/B/AR/R.
- C_AXI_ADDR_WIDTH, 32, byte address width.
- C_AXI_DATA_WIDTH, 32, data width; power of two, at least 8.
- MEM_DEPTH, 1024, RAM depth in data words; power of two.
- clk  in  1  single clock; all logic on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- axi_aw{id,addr,len,size,burst,valid}  in  ID/ADDR/8/3/2/1  write address channel.
- axi_awready  out  1.
- axi_w{data,strb,last,valid}  in  DATA/DATA/8/1/1  write data channel.
- axi_wready  out  1.
- axi_b{id,resp,valid}  out  ID/2/1  write response; axi_bready in 1.
- axi_ar{id,addr,len,size,burst,valid}  in  read address channel.
- axi_arready  out  1.
- axi_r{id,data,resp,last,valid}  out  read data channel; axi_rready in 1.
- idle  out  1  both channel FSMs idle.
- proto_err  out  1  sticky: WLAST mismatch seen; cleared only by rst.

## Operation
- Word index = (addr >> log2(DATA_WIDTH/8)) mod MEM_DEPTH; byte-offset bits ignored; size ignored (full-width beats); any burst type treated as INCR; next beat = index + 1, wrapping at MEM_DEPTH.
- Write FSM: W_IDLE -> W_DATA -> W_RESP -> W_IDLE.
  - W_IDLE: awready=1; on AW handshake latch id, index, len (beats = len+1).
  - W_DATA: wready=1; each W handshake writes bytes enabled by wstrb; beat counter increments.
  - On final beat (counter == len), go to W_RESP. wlast must equal (counter == len); a mismatch on any beat sets proto_err, but the burst length is still taken from len.
  - W_RESP: bvalid=1, bid=latched id, bresp=OKAY; on B handshake go to W_IDLE.
- Read FSM: R_IDLE -> R_FETCH -> R_DATA -> R_IDLE.
  - R_IDLE: arready=1; on AR handshake latch id, index, len, and issue the RAM read of the first word.
  - R_FETCH: one cycle; RAM data is registered.
  - R_DATA: rvalid=1, rid=latched id, rresp=OKAY, rlast=(beat == len). On each R handshake that is not last, issue the next RAM read in the same cycle so rdata updates next cycle (no bubble). After the last handshake go to R_IDLE.
  - rdata/rlast are held stable while rvalid=1 and rready=0.
- Same-cycle write and read of one word: the read returns old data (read-first).
- idle = (W_IDLE && R_IDLE).

## Timing
- Reset values: awready=0, wready=0, bvalid=0, arready=0, rvalid=0, rlast=0, bresp/rresp=0, bid/rid=0, rdata=0, proto_err=0, idle=1.
- RAM contents are not cleared by reset.
- awready and arready rise in the first clk after rst deasserts.
- AW handshake at cycle t: wready=1 from t+1.
- Last W beat at t: bvalid=1 at t+1.
- AR handshake at t: rvalid=1 at t+2.
- Sustained throughput: one beat per cycle on W and on R.
- Ready signals are registered outputs; there is no combinational path from any valid input to a ready output.
- rst asserted mid-burst: both FSMs go immediately to IDLE and all valids/readies drop. A partial write burst leaves already-written beats in RAM.

## Configuration
- AXI_RESP_RANGE_CHK_EN defined: any beat whose unwrapped word index is >= MEM_DEPTH gets SLVERR (2'b10).
  - Out-of-range write beats are not written; bresp is SLVERR if any beat of the burst was out of range.
  - Out-of-range read beats return rdata=0 with rresp=SLVERR.
- Macro undefined: addresses wrap modulo MEM_DEPTH and all responses are OKAY.

## Structure
- Package axi_mem_pkg: response codes (OKAY=2'b00, SLVERR=2'b10), INCR burst code, write-FSM and read-FSM state encodings.
- Sub-module axi_mem_ram: simple dual-port RAM with one byte-enabled write port and one registered read port with read enable, read-first. Depth MEM_DEPTH, width C_AXI_DATA_WIDTH.

## Test plan
- Reset, then AW addr=0x0 len=7 followed by 8 W beats 0x11..0x88, bready=1 -> bvalid 1 cycle after the 8th beat, bresp=0, bid matches awid; AR addr=0x0 len=7 -> rdata 0x11..0x88, rlast only on the 8th beat.
- Write 0xAABBCCDD with wstrb=4'b0101 over 0x00000000 -> readback returns 0x00BB00DD.
- 16-beat read with rready toggling every cycle -> rdata/rlast stable while stalled, no beats lost or duplicated.
- Write burst len=3 with wlast asserted on the 2nd beat -> proto_err=1, still 4 beats accepted, single B response.
- Concurrent 8-beat write at 0x100 and 8-beat read at 0x100 starting the same cycle -> read returns the prior contents; completes in 10 cycles.
- Burst at word index MEM_DEPTH-2, len=3 -> with AXI_RESP_RANGE_CHK_EN: last 2 beats SLVERR, not written; without it: writes wrap to indices 0 and 1, resp OKAY.
